// File: rtl/fpga_dma_req_pkg.sv
// Shared channel state encoding and default parameters for the DMA request generator.
// No logic; imported by the channel and top modules.
package fpga_dma_req_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_PEND_W      = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } ch_state_e;

    // Width of a counter that must hold values 0..cyc-1 (at least one bit).
    function automatic int tmo_width(input int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/fpga_dma_req_chan.sv
// One DMA channel: four-phase REQ/ACK handshake, saturating pending counter, REQ timeout, sticky flags.
// REQ is registered and rises one edge after the pending count is non-zero; ACK must return low before the next REQ.
module fpga_dma_req_chan
    import fpga_dma_req_pkg::*;
#(
    parameter int PEND_W      = DEF_PEND_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_xfer_inc,
    input  logic              i_ch_en,
    input  logic              i_err_clr,
    input  logic              i_ack,
    output logic              o_req,
    output logic [PEND_W-1:0] o_pend_cnt,
    output logic              o_err,
    output logic              o_ovf,
    output logic              o_busy
);

    localparam int                TMO_W    = tmo_width(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [PEND_W-1:0] CNT_MAX  = '1;

    ch_state_e         r_state, w_state_nxt;
    logic [PEND_W-1:0] r_cnt, w_cnt_nxt;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic              r_req, w_req_nxt;
    logic              r_err, w_err_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic              w_dec;
    logic              w_tmo_hit;
    logic              w_ovf_set;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_req   <= w_req_nxt;
            r_err   <= w_err_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_tmo_nxt   = r_tmo;
        w_dec       = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                w_tmo_nxt = '0;
                if ((r_cnt != '0) && i_ch_en && !r_err && !i_ack) begin
                    w_state_nxt = REQ;
                    w_req_nxt   = 1'b1;
                end
            end
            REQ: begin
                if (i_ack) begin
                    w_state_nxt = WAIT_LOW;
                    w_req_nxt   = 1'b0;
                    w_dec       = 1'b1;
                    w_tmo_nxt   = '0;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_tmo_hit   = 1'b1;
                    w_tmo_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            WAIT_LOW: begin
                w_tmo_nxt = '0;
                if (!i_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    // A timeout discards the backlog, but an increment on that same edge still lands.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_set = 1'b0;
        if (w_tmo_hit) begin
            w_cnt_nxt = PEND_W'(i_xfer_inc);
        end else if (i_xfer_inc && !w_dec) begin
            if (r_cnt == CNT_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + PEND_W'(1);
            end
        end else if (w_dec && !i_xfer_inc) begin
            w_cnt_nxt = r_cnt - PEND_W'(1);
        end
    end

    assign w_err_nxt = (r_err & ~i_err_clr) | w_tmo_hit;
    assign w_ovf_nxt = (r_ovf & ~i_err_clr) | w_ovf_set;

    assign o_req      = r_req;
    assign o_pend_cnt = r_cnt;
    assign o_err      = r_err;
    assign o_ovf      = r_ovf;
    assign o_busy     = (r_state != IDLE) || (r_cnt != '0);

endmodule

// File: rtl/fpga_dma_req_gen.sv
// NUM_CH independent DMA request channels toward a SoC DMA REQ/ACK interface, plus an aggregate BUSY.
// Per-channel latency and flow control are those of fpga_dma_req_chan; BUSY is combinational from registers.
module fpga_dma_req_gen
    import fpga_dma_req_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int PEND_W      = DEF_PEND_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     DMA_CLK,
    input  logic                     DMA_RST_N,
    input  logic [NUM_CH-1:0]        XFER_INC,
    input  logic [NUM_CH-1:0]        CH_EN,
    input  logic [NUM_CH-1:0]        ERR_CLR,
    input  logic [NUM_CH-1:0]        DMA_ACK,
    output logic [NUM_CH-1:0]        DMA_REQ,
    output logic [NUM_CH*PEND_W-1:0] PEND_CNT,
    output logic [NUM_CH-1:0]        ERR,
    output logic [NUM_CH-1:0]        OVF,
    output logic                     BUSY
);

    logic [NUM_CH-1:0] w_busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fpga_dma_req_chan #(
            .PEND_W      (PEND_W),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_chan (
            .i_clk      (DMA_CLK),
            .i_rst_n    (DMA_RST_N),
            .i_xfer_inc (XFER_INC[g]),
            .i_ch_en    (CH_EN[g]),
            .i_err_clr  (ERR_CLR[g]),
            .i_ack      (DMA_ACK[g]),
            .o_req      (DMA_REQ[g]),
            .o_pend_cnt (PEND_CNT[g*PEND_W +: PEND_W]),
            .o_err      (ERR[g]),
            .o_ovf      (OVF[g]),
            .o_busy     (w_busy[g])
        );
    end

    assign BUSY = |w_busy;

endmodule

// File: tb/tb_fpga_dma_req_gen.sv
// Directed bench for fpga_dma_req_gen: handshake, back-to-back, timeout, saturation, collisions and reset.
module tb_fpga_dma_req_gen;

    localparam int NUM_CH = 4;
    localparam int PEND_W = 4;
    localparam int TMO    = 16;

    logic                     DMA_CLK = 1'b0;
    logic                     DMA_RST_N;
    logic [NUM_CH-1:0]        XFER_INC;
    logic [NUM_CH-1:0]        CH_EN;
    logic [NUM_CH-1:0]        ERR_CLR;
    logic [NUM_CH-1:0]        DMA_ACK;
    logic [NUM_CH-1:0]        DMA_REQ;
    logic [NUM_CH*PEND_W-1:0] PEND_CNT;
    logic [NUM_CH-1:0]        ERR;
    logic [NUM_CH-1:0]        OVF;
    logic                     BUSY;

    int n_chk  = 0;
    int n_pass = 0;

    fpga_dma_req_gen #(
        .NUM_CH      (NUM_CH),
        .PEND_W      (PEND_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .DMA_CLK   (DMA_CLK),
        .DMA_RST_N (DMA_RST_N),
        .XFER_INC  (XFER_INC),
        .CH_EN     (CH_EN),
        .ERR_CLR   (ERR_CLR),
        .DMA_ACK   (DMA_ACK),
        .DMA_REQ   (DMA_REQ),
        .PEND_CNT  (PEND_CNT),
        .ERR       (ERR),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    always #5 DMA_CLK = ~DMA_CLK;

    task automatic tick();
        @(posedge DMA_CLK);
        #1;
    endtask

    task automatic pulse_inc(input int ch);
        XFER_INC[ch] = 1'b1;
        tick();
        XFER_INC[ch] = 1'b0;
    endtask

    function automatic logic [31:0] pc(input int ch);
        return 32'(PEND_CNT[ch*PEND_W +: PEND_W]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        DMA_RST_N = 1'b0;
        XFER_INC  = '0;
        CH_EN     = '0;
        ERR_CLR   = '0;
        DMA_ACK   = '0;
        tick();
        tick();
        check("rst_req",  32'(DMA_REQ),  0);
        check("rst_cnt",  32'(PEND_CNT), 0);
        check("rst_err",  32'(ERR),      0);
        check("rst_ovf",  32'(OVF),      0);
        check("rst_busy", 32'(BUSY),     0);
        DMA_RST_N = 1'b1;
        CH_EN     = 4'b0111;
        tick();

        // Basic handshake on ch0, ACK echoing REQ one cycle late
        pulse_inc(0);
        check("hs_cnt1",    pc(0), 1);
        check("hs_req_lo",  32'(DMA_REQ[0]), 0);
        check("hs_busy",    32'(BUSY), 1);
        tick();
        check("hs_req_rise", 32'(DMA_REQ[0]), 1);
        tick();
        check("hs_req_hold", 32'(DMA_REQ[0]), 1);
        DMA_ACK[0] = 1'b1;
        tick();
        check("hs_req_fall", 32'(DMA_REQ[0]), 0);
        check("hs_cnt0",     pc(0), 0);
        check("hs_busy_wl",  32'(BUSY), 1);
        tick();
        check("hs_busy_wl2", 32'(BUSY), 1);
        DMA_ACK[0] = 1'b0;
        tick();
        check("hs_busy_drop", 32'(BUSY), 0);
        check("hs_req_idle",  32'(DMA_REQ[0]), 0);

        // Back-to-back: three pending transfers on ch1
        CH_EN[1] = 1'b0;
        pulse_inc(1);
        check("b2b_cnt1", pc(1), 1);
        pulse_inc(1);
        check("b2b_cnt2", pc(1), 2);
        pulse_inc(1);
        check("b2b_cnt3", pc(1), 3);
        CH_EN[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_req_hi",  32'(DMA_REQ[1]), 1);
            check("b2b_cnt_req", pc(1), 32'(3 - i));
            DMA_ACK[1] = 1'b1;
            tick();
            check("b2b_req_lo",  32'(DMA_REQ[1]), 0);
            check("b2b_cnt_dec", pc(1), 32'(2 - i));
            tick();
            check("b2b_holdoff", 32'(DMA_REQ[1]), 0);
            DMA_ACK[1] = 1'b0;
            tick();
            check("b2b_idle",    32'(DMA_REQ[1]), 0);
        end
        check("b2b_cnt_end",  pc(1), 0);
        check("b2b_busy_end", 32'(BUSY), 0);

        // Timeout on ch2 with ACK held low
        CH_EN[2] = 1'b0;
        pulse_inc(2);
        pulse_inc(2);
        check("to_cnt2", pc(2), 2);
        CH_EN[2] = 1'b1;
        tick();
        check("to_req_rise", 32'(DMA_REQ[2]), 1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (DMA_REQ[2]) n++;
            else break;
        end
        check("to_req_cycles", 32'(n), 16);
        check("to_err",  32'(ERR[2]), 1);
        check("to_cnt0", pc(2), 0);
        pulse_inc(2);
        check("to_inc_in_err", pc(2), 1);
        tick();
        tick();
        tick();
        check("to_blocked", 32'(DMA_REQ[2]), 0);
        ERR_CLR[2] = 1'b1;
        tick();
        ERR_CLR[2] = 1'b0;
        check("to_err_clr", 32'(ERR[2]), 0);
        check("to_req_clr_edge", 32'(DMA_REQ[2]), 0);
        tick();
        check("to_req_after_clr", 32'(DMA_REQ[2]), 1);
        DMA_ACK[2] = 1'b1;
        tick();
        check("to_cnt_after_ack", pc(2), 0);
        DMA_ACK[2] = 1'b0;
        tick();
        check("to_busy_end", 32'(BUSY), 0);

        // Increment colliding with the ACK edge on ch0, then CH_EN drop mid-handshake
        pulse_inc(0);
        tick();
        check("sim_req1", 32'(DMA_REQ[0]), 1);
        DMA_ACK[0]  = 1'b1;
        XFER_INC[0] = 1'b1;
        tick();
        XFER_INC[0] = 1'b0;
        check("sim_req_lo", 32'(DMA_REQ[0]), 0);
        check("sim_cnt",    pc(0), 1);
        tick();
        check("sim_holdoff", 32'(DMA_REQ[0]), 0);
        DMA_ACK[0] = 1'b0;
        tick();
        check("sim_idle", 32'(DMA_REQ[0]), 0);
        tick();
        check("sim_req2", 32'(DMA_REQ[0]), 1);
        CH_EN[0] = 1'b0;
        tick();
        check("en_drop_hold", 32'(DMA_REQ[0]), 1);
        DMA_ACK[0] = 1'b1;
        tick();
        check("en_drop_done_req", 32'(DMA_REQ[0]), 0);
        check("en_drop_done_cnt", pc(0), 0);
        DMA_ACK[0] = 1'b0;
        tick();
        CH_EN[0] = 1'b1;

        // ACK high while IDLE holds off a new request
        DMA_ACK[0] = 1'b1;
        pulse_inc(0);
        tick();
        tick();
        check("idle_ack_holdoff", 32'(DMA_REQ[0]), 0);
        DMA_ACK[0] = 1'b0;
        tick();
        check("idle_ack_release", 32'(DMA_REQ[0]), 1);
        DMA_ACK[0] = 1'b1;
        tick();
        DMA_ACK[0] = 1'b0;
        tick();
        check("idle_ack_busy_end", 32'(BUSY), 0);

        // Saturation on ch3 with CH_EN low
        for (int i = 0; i < 15; i++) pulse_inc(3);
        check("sat_cnt15",  pc(3), 15);
        check("sat_no_ovf", 32'(OVF[3]), 0);
        pulse_inc(3);
        check("sat_cnt_hold", pc(3), 15);
        check("sat_ovf",      32'(OVF[3]), 1);
        check("sat_req",      32'(DMA_REQ[3]), 0);
        ERR_CLR[3] = 1'b1;
        tick();
        ERR_CLR[3] = 1'b0;
        check("sat_ovf_clr",  32'(OVF[3]), 0);
        check("sat_cnt_kept", pc(3), 15);

        // Reset in the middle of a REQ phase on ch1
        CH_EN[1] = 1'b0;
        for (int i = 0; i < 5; i++) pulse_inc(1);
        check("mrst_cnt5", pc(1), 5);
        CH_EN[1] = 1'b1;
        tick();
        check("mrst_req", 32'(DMA_REQ[1]), 1);
        tick();
        DMA_RST_N = 1'b0;
        tick();
        check("mrst_req_lo", 32'(DMA_REQ), 0);
        check("mrst_cnt",    32'(PEND_CNT), 0);
        check("mrst_busy",   32'(BUSY), 0);
        check("mrst_flags",  32'({ERR, OVF}), 0);
        DMA_RST_N = 1'b1;
        tick();
        check("mrst_stay_idle", 32'(DMA_REQ[1]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
